// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package add_serial_pkg;

    localparam int ADD_SERIAL_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_01bit_full.sv
// Single-bit full adder; the only arithmetic element of the serial controller.
module add_01bit_full (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/add_serial_ctrl.sv
// Bit-serial add/subtract controller: one full adder, LSB first, one bit per clock.
// Optional subtraction is enabled by defining macro ADD_SERIAL_SUB_EN.
module add_serial_ctrl
    import add_serial_pkg::*;
#(
    parameter int DATA_WIDTH = ADD_SERIAL_DEFAULT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_sub,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_ovf
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    cry_q, cry_d;
    logic                    msbCin_q, msbCin_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sumBit;
    logic                    carryOut;

`ifdef ADD_SERIAL_SUB_EN
    logic                    subSel;
    assign subSel = i_sub;
`else
    logic                    unusedSub;
    assign unusedSub = i_sub;
`endif

    add_01bit_full u_fa (
        .i_a (a_q[0]),
        .i_b (b_q[0]),
        .i_c (cry_q),
        .o_s (sumBit),
        .o_c (carryOut)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cry_d    = cry_q;
        msbCin_d = msbCin_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_vld) begin
                    a_d      = i_num_a;
`ifdef ADD_SERIAL_SUB_EN
                    b_d      = subSel ? ~i_num_b : i_num_b;
                    cry_d    = subSel;
`else
                    b_d      = i_num_b;
                    cry_d    = 1'b0;
`endif
                    msbCin_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {sumBit, res_q[DATA_WIDTH-1:1]};
                cry_d = carryOut;
                // The counter parks on the last bit so it never wraps.
                if (cnt_q == LAST_BIT) begin
                    msbCin_d = cry_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cry_q    <= 1'b0;
            msbCin_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cry_q    <= cry_d;
            msbCin_q <= msbCin_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held so they are defined from time zero.
    assign o_rdy = (state_q == IDLE) && !i_rst;
    assign o_vld = (state_q == DONE) && !i_rst;
    assign o_res = i_rst ? '0 : res_q;
    assign o_cry = !i_rst && cry_q;
    assign o_ovf = !i_rst && (msbCin_q ^ cry_q);

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Self-checking bench for add_serial_ctrl at DATA_WIDTH=8; honours ADD_SERIAL_SUB_EN if defined.
module tb_add_serial_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         cry;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cry;
        logic         ovf;
        int           acceptCyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_vld = 1'b0;
    logic         o_rdy;
    logic [W-1:0] i_num_a = '0;
    logic [W-1:0] i_num_b = '0;
    logic         i_sub = 1'b0;
    logic         o_vld;
    logic         i_rdy = 1'b1;
    logic [W-1:0] o_res;
    logic         o_cry;
    logic         o_ovf;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prevVld = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    add_serial_ctrl #(.DATA_WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .i_sub   (i_sub),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_res   (o_res),
        .o_cry   (o_cry),
        .o_ovf   (o_ovf)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t modelAdd(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         useSub;
`ifdef ADD_SERIAL_SUB_EN
        useSub = sub;
`else
        useSub = 1'b0 & sub;
`endif
        bb          = useSub ? ~b : b;
        s           = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, useSub};
        e.res       = s[W-1:0];
        e.cry       = s[W];
        e.ovf       = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        e.acceptCyc = 0;
        return e;
    endfunction

    // Scoreboard: every DONE cycle is compared against the oldest outstanding request.
    always @(negedge clk) begin
        if (!i_rst && o_vld) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
                checkOutput("res", 64'(o_res), 64'(sbq[0].res));
                checkOutput("cry", 64'(o_cry), 64'(sbq[0].cry));
                checkOutput("ovf", 64'(o_ovf), 64'(sbq[0].ovf));
                if (!prevVld) checkOutput("latency", 64'(cyc - sbq[0].acceptCyc), 64'(W));
                if (i_rdy) void'(sbq.pop_front());
            end
        end
        prevVld = o_vld;
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 input exp_t e, output int acceptCyc);
        int   n = 0;
        exp_t x = e;
        acceptCyc = -1;
        @(negedge clk);
        while (!o_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_rdy) begin
            checkOutput("rdy_timeout", 64'd0, 64'd1);
            return;
        end
        i_vld   = 1'b1;
        i_num_a = a;
        i_num_b = b;
        i_sub   = sub;
        @(posedge clk);
        #1;
        x.acceptCyc = cyc;
        acceptCyc   = cyc;
        sbq.push_back(x);
        i_vld   = 1'b0;
        i_num_a = W'($urandom_range(255));
        i_num_b = W'($urandom_range(255));
        i_sub   = 1'($urandom_range(1));
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_rdy"}, 64'(o_rdy), 64'd1);
        checkOutput({tag, "_vld"}, 64'(o_vld), 64'd0);
        checkOutput({tag, "_res"}, 64'(o_res), 64'd0);
        checkOutput({tag, "_cry"}, 64'(o_cry), 64'd0);
        checkOutput({tag, "_ovf"}, 64'(o_ovf), 64'd0);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e;
        int   acc;
        int   prevAcc;
        int   n;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0};
`ifdef ADD_SERIAL_SUB_EN
        vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
        vecs[6] = '{8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0};
`endif

        // Reset state: everything low while reset is held, ready right after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rdy", 64'(o_rdy), 64'd0);
        checkOutput("rst_vld", 64'(o_vld), 64'd0);
        checkOutput("rst_res", 64'(o_res), 64'd0);
        checkOutput("rst_cry", 64'(o_cry), 64'd0);
        checkOutput("rst_ovf", 64'(o_ovf), 64'd0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        checkIdleZero("post_rst");

        prevAcc = 0;
        for (int i = 0; i < 8; i++) begin
            e.res = vecs[i].res;
            e.cry = vecs[i].cry;
            e.ovf = vecs[i].ovf;
            e.acceptCyc = 0;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, e, acc);
            if (i > 0) checkOutput("spacing", 64'(acc - prevAcc), 64'(W + 2));
            prevAcc = acc;
        end
        waitDrain();

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom_range(255));
            rb = W'($urandom_range(255));
            rs = 1'($urandom_range(1));
            applyStimulus(ra, rb, rs, modelAdd(ra, rb, rs), acc);
        end
        waitDrain();

        // Back-pressure in DONE plus stray i_vld pulses that must be ignored.
        i_rdy = 1'b0;
        applyStimulus(8'h5A, 8'h33, 1'b0, modelAdd(8'h5A, 8'h33, 1'b0), acc);
        @(posedge clk); #1 i_vld = 1'b1;
        @(posedge clk); #1 i_vld = 1'b0;
        @(negedge clk);
        checkOutput("rdy_in_calc", 64'(o_rdy), 64'd0);
        n = 0;
        while (!o_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("vld_wait", 64'(o_vld), 64'd1);
        @(posedge clk); #1 i_vld = 1'b1;
        @(posedge clk); #1 i_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("hold_vld", 64'(o_vld), 64'd1);
        checkOutput("hold_res", 64'(o_res), 64'h8D);
        @(posedge clk); #1 i_rdy = 1'b1;
        waitDrain();
        repeat (W + 4) @(negedge clk);

        // Reset during the 4th CALC cycle aborts the operation.
        applyStimulus(8'hAA, 8'h55, 1'b0, modelAdd(8'hAA, 8'h55, 1'b0), acc);
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        checkOutput("midrst_rdy", 64'(o_rdy), 64'd0);
        checkOutput("midrst_vld", 64'(o_vld), 64'd0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        checkIdleZero("after_midrst");
        applyStimulus(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0, 0}, acc);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
